// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter
// Shares one MMIO data bus between the core data port (core_*) and the
// DMA/debug port (dma_*). One transaction at a time, round-robin on ties,
// bus signals held stable while waiting for bus_ready, and a hung access is
// completed with an error after TIMEOUT busy cycles.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   core_req/addr/wdata/read   core request (held until core_ack)
//   core_rdata/ack/err         core completion (ack/err one-cycle pulses)
//   dma_*                      same set for the DMA/debug port
//   bus_address/store/read/enable  to the MMIO decoder
//   bus_fetch, bus_ready       read data and completion strobe from slots
//   busy                       high in BUSY or DONE
//   grant_id                   0=core, 1=dma; owner of current/last access
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; pick a winner when any request is present
// BUSY  | bus_enable high, waiting for bus_ready or timeout
// DONE  | one-cycle ack (and err on timeout) to the granted port
module mmio_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic        core_read,
  output logic [31:0] core_rdata,
  output logic        core_ack,
  output logic        core_err,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_read,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] bus_address,
  output logic [31:0] bus_store,
  output logic        bus_read,
  output logic        bus_enable,
  input  logic [31:0] bus_fetch,
  input  logic        bus_ready,
  output logic        busy,
  output logic        grant_id
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_grant;

  // On a tie the port that did not win last time is served.
  logic w_pick_dma;
  logic w_any_req;
  logic w_timeout;
  logic w_finish;
  logic w_fin_err;
  logic [31:0] w_fin_data;

  assign w_any_req  = core_req | dma_req;
  assign w_pick_dma = dma_req & (~core_req | ~r_last_grant);
  // bus_ready on the final counted cycle wins over the timeout.
  assign w_timeout  = ~bus_ready & (r_cnt == CNT_LAST);
  assign w_finish   = bus_ready | w_timeout;
  assign w_fin_err  = ~bus_ready;
  assign w_fin_data = bus_ready ? (bus_read ? bus_fetch : 32'h0) : ERR_DATA;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      bus_address  <= 32'h0;
      bus_store    <= 32'h0;
      bus_read     <= 1'b0;
      bus_enable   <= 1'b0;
      core_rdata   <= 32'h0;
      core_ack     <= 1'b0;
      core_err     <= 1'b0;
      dma_rdata    <= 32'h0;
      dma_ack      <= 1'b0;
      dma_err      <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            bus_address <= w_pick_dma ? dma_addr  : core_addr;
            bus_store   <= w_pick_dma ? dma_wdata : core_wdata;
            bus_read    <= w_pick_dma ? dma_read  : core_read;
            grant_id    <= w_pick_dma;
            r_cnt       <= '0;
            bus_enable  <= 1'b1;
            busy        <= 1'b1;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_finish) begin
            bus_enable <= 1'b0;
            r_state    <= S_DONE;
            if (grant_id) begin
              dma_ack   <= 1'b1;
              dma_err   <= w_fin_err;
              dma_rdata <= w_fin_data;
            end else begin
              core_ack   <= 1'b1;
              core_err   <= w_fin_err;
              core_rdata <= w_fin_data;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          core_ack     <= 1'b0;
          core_err     <= 1'b0;
          dma_ack      <= 1'b0;
          dma_err      <= 1'b0;
          busy         <= 1'b0;
          r_last_grant <= grant_id;
          r_state      <= S_IDLE;
        end
        default: begin
          bus_enable <= 1'b0;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
module tb_mmio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_read, dma_req, dma_read;
  logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;
  logic [31:0] core_rdata, dma_rdata;
  logic        core_ack, core_err, dma_ack, dma_err;
  logic [31:0] bus_address, bus_store, bus_fetch;
  logic        bus_read, bus_enable, bus_ready, busy, grant_id;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_c_rdata = 32'h0;
  logic [31:0] exp_d_rdata = 32'h0;

  always #5 clk = ~clk;

  mmio_bus_arbiter #(.TIMEOUT(16), .ERR_DATA(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_read(core_read), .core_rdata(core_rdata), .core_ack(core_ack),
    .core_err(core_err),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_read(dma_read), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .dma_err(dma_err),
    .bus_address(bus_address), .bus_store(bus_store), .bus_read(bus_read),
    .bus_enable(bus_enable), .bus_fetch(bus_fetch), .bus_ready(bus_ready),
    .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    logic        c_req;
    logic        d_req;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_read;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_read;
    int          rdy;        // BUSY cycle (1-based) carrying bus_ready; 0 = never
    logic [31:0] fetch;
    logic        exp_grant;
    int          exp_busy;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic cr, input logic dr,
                              input logic [31:0] ca, input logic [31:0] cw, input logic crd,
                              input logic [31:0] da, input logic [31:0] dw, input logic drd,
                              input int rdy, input logic [31:0] f,
                              input logic eg, input int eb, input logic [31:0] ed,
                              input logic ee);
    vec_t v;
    v.c_req = cr; v.d_req = dr;
    v.c_addr = ca; v.c_wdata = cw; v.c_read = crd;
    v.d_addr = da; v.d_wdata = dw; v.d_read = drd;
    v.rdy = rdy; v.fetch = f;
    v.exp_grant = eg; v.exp_busy = eb; v.exp_rdata = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_vec(input vec_t v, input string nm);
    int nbusy, en_cyc, ack_cyc;
    bit got, stable_ok;
    logic [31:0] ea, es;
    logic er;
    core_req = v.c_req; core_addr = v.c_addr; core_wdata = v.c_wdata; core_read = v.c_read;
    dma_req = v.d_req; dma_addr = v.d_addr; dma_wdata = v.d_wdata; dma_read = v.d_read;
    bus_fetch = v.fetch; bus_ready = 1'b0;
    ea = v.exp_grant ? v.d_addr  : v.c_addr;
    es = v.exp_grant ? v.d_wdata : v.c_wdata;
    er = v.exp_grant ? v.d_read  : v.c_read;
    nbusy = 0; en_cyc = -1; ack_cyc = -1; got = 0; stable_ok = 1;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      if (bus_enable) begin
        if (en_cyc < 0) en_cyc = cyc;
        nbusy++;
        if (bus_address !== ea || bus_store !== es || bus_read !== er || busy !== 1'b1)
          stable_ok = 0;
        bus_ready = (nbusy == v.rdy);
      end else begin
        bus_ready = 1'b0;
        if (core_ack || dma_ack) begin
          got = 1;
          ack_cyc = cyc;
          chk({nm, " grant_id"}, grant_id, v.exp_grant);
          chk({nm, " busy_cycles"}, nbusy, v.exp_busy);
          chk({nm, " latency"}, ack_cyc, 1 + v.exp_busy);
          chk({nm, " first_enable"}, en_cyc, 1);
          chk({nm, " bus_stable"}, stable_ok, 1);
          chk({nm, " busy_in_done"}, busy, 1);
          chk({nm, " core_ack"}, core_ack, !v.exp_grant);
          chk({nm, " dma_ack"}, dma_ack, v.exp_grant);
          if (v.exp_grant) begin
            chk({nm, " dma_rdata"}, dma_rdata, v.exp_rdata);
            chk({nm, " dma_err"}, dma_err, v.exp_err);
            chk({nm, " core_err_quiet"}, core_err, 0);
            chk({nm, " core_rdata_hold"}, core_rdata, exp_c_rdata);
            exp_d_rdata = v.exp_rdata;
          end else begin
            chk({nm, " core_rdata"}, core_rdata, v.exp_rdata);
            chk({nm, " core_err"}, core_err, v.exp_err);
            chk({nm, " dma_err_quiet"}, dma_err, 0);
            chk({nm, " dma_rdata_hold"}, dma_rdata, exp_d_rdata);
            exp_c_rdata = v.exp_rdata;
          end
          core_req = 1'b0;
          dma_req  = 1'b0;
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s ack_timeout: got no ack expected ack within 40 cycles", nm);
      core_req = 1'b0; dma_req = 1'b0;
    end
    @(negedge clk);
    chk({nm, " ack_one_cycle"}, {core_ack, dma_ack}, 0);
  endtask

  vec_t vecs[8];
  vec_t v_pre, v_post;

  initial begin
    int acks, nb;
    bit got1, got2;

    vecs[0] = mk(1, 0, 32'h0020_0400, 32'h0, 1, 32'h0, 32'h0, 0, 1, 32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D, 0);
    vecs[1] = mk(1, 1, 32'h0020_0010, 32'h0, 1, 32'h0020_0014, 32'h0, 1, 1, 32'h1111_2222, 1, 1, 32'h1111_2222, 0);
    vecs[2] = mk(1, 1, 32'h0020_0010, 32'h0, 1, 32'h0020_0014, 32'h0, 1, 2, 32'h3333_4444, 0, 2, 32'h3333_4444, 0);
    vecs[3] = mk(0, 1, 32'h0, 32'h0, 0, 32'h0020_0800, 32'h1234_5678, 0, 4, 32'hFFFF_FFFF, 1, 4, 32'h0, 0);
    vecs[4] = mk(1, 0, 32'h0020_0C00, 32'h0, 1, 32'h0, 32'h0, 0, 0, 32'h5555_AAAA, 0, 16, 32'h0, 1);
    vecs[5] = mk(1, 0, 32'h0020_0C04, 32'h0, 1, 32'h0, 32'h0, 0, 16, 32'hA5A5_5A5A, 0, 16, 32'hA5A5_5A5A, 0);
    vecs[6] = mk(0, 1, 32'h0, 32'h0, 0, 32'h0020_1000, 32'h0, 1, 2, 32'hDEAD_BEEF, 1, 2, 32'hDEAD_BEEF, 0);
    vecs[7] = mk(0, 1, 32'h0, 32'h0, 0, 32'h0020_0804, 32'h0BAD_C0DE, 0, 1, 32'h7777_7777, 1, 1, 32'h0, 0);
    v_pre   = mk(1, 0, 32'h0020_0100, 32'h0, 1, 32'h0, 32'h0, 0, 1, 32'h1357_9BDF, 0, 1, 32'h1357_9BDF, 0);
    v_post  = mk(1, 1, 32'h0020_0200, 32'h0, 1, 32'h0020_0204, 32'h0, 1, 1, 32'h2468_ACE0, 0, 1, 32'h2468_ACE0, 0);

    rst_n = 1'b0;
    core_req = 0; core_addr = 0; core_wdata = 0; core_read = 0;
    dma_req = 0; dma_addr = 0; dma_wdata = 0; dma_read = 0;
    bus_fetch = 32'h0; bus_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst bus_enable", bus_enable, 0);
    chk("rst bus_address", bus_address, 0);
    chk("rst bus_store", bus_store, 0);
    chk("rst bus_read", bus_read, 0);
    chk("rst rdata", {core_rdata, dma_rdata} == 64'h0, 1);
    chk("rst acks_errs", {core_ack, core_err, dma_ack, dma_err}, 0);
    chk("rst busy", busy, 0);
    chk("rst grant_id", grant_id, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both held from reset: core first, then strict alternation.
    core_req = 1; core_addr = 32'h0020_0040; core_read = 1;
    dma_req = 1; dma_addr = 32'h0020_0044; dma_read = 1;
    bus_fetch = 32'h0F0F_0F0F;
    acks = 0;
    for (int cyc = 0; cyc < 60 && acks < 4; cyc++) begin
      @(negedge clk);
      bus_ready = bus_enable;
      if (core_ack || dma_ack) begin
        chk($sformatf("alt grant %0d", acks), grant_id, acks % 2);
        chk($sformatf("alt core_ack %0d", acks), core_ack, (acks % 2) == 0);
        if (acks % 2 == 0) exp_c_rdata = 32'h0F0F_0F0F;
        else exp_d_rdata = 32'h0F0F_0F0F;
        acks++;
        if (acks == 4) begin core_req = 0; dma_req = 0; end
      end
    end
    if (acks < 4) begin
      checks++; errors++;
      $display("FAIL alt ack_count: got %0d expected 4", acks);
      core_req = 0; dma_req = 0;
    end
    bus_ready = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Timeout on core while dma waits; dma is served right after the error.
    core_req = 1; core_addr = 32'h0020_0F00; core_read = 1;
    dma_req = 1; dma_addr = 32'h0020_0F04; dma_wdata = 32'h5A5A_0001; dma_read = 0;
    bus_fetch = 32'hEEEE_EEEE; bus_ready = 0;
    nb = 0; got1 = 0; got2 = 0;
    for (int cyc = 0; cyc < 60 && !got2; cyc++) begin
      @(negedge clk);
      if (bus_enable) begin
        nb++;
        bus_ready = got1;
      end else begin
        bus_ready = 1'b0;
        if (core_ack && !got1) begin
          got1 = 1;
          chk("to core_err", core_err, 1);
          chk("to core_rdata", core_rdata, 32'h0);
          chk("to busy_cycles", nb, 16);
          chk("to dma_ack_quiet", dma_ack, 0);
          exp_c_rdata = 32'h0;
          core_req = 0;
        end else if (dma_ack) begin
          got2 = 1;
          chk("to dma_grant", grant_id, 1);
          chk("to dma_err", dma_err, 0);
          chk("to dma_rdata", dma_rdata, 32'h0);
          chk("to dma_after_core", got1, 1);
          exp_d_rdata = 32'h0;
          dma_req = 0;
        end
      end
    end
    if (!got2) begin
      checks++; errors++;
      $display("FAIL to ack_timeout: got no dma ack expected one");
      core_req = 0; dma_req = 0;
    end
    @(negedge clk);

    // bus_ready while idle must do nothing.
    bus_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready quiet", {core_ack, dma_ack, busy, bus_enable}, 0);
    bus_ready = 1'b0;
    @(negedge clk);

    // Reset in the middle of BUSY after a core win: no ack, core wins the next tie.
    run_vec(v_pre, "pre_rst");
    core_req = 1; core_addr = 32'h0020_0300; core_read = 1;
    repeat (3) @(negedge clk);
    chk("mid bus_enable_before", bus_enable, 1);
    rst_n = 1'b0;
    #1;
    chk("mid bus_enable", bus_enable, 0);
    chk("mid busy", busy, 0);
    chk("mid no_ack", {core_ack, dma_ack}, 0);
    chk("mid core_rdata", core_rdata, 32'h0);
    exp_c_rdata = 32'h0; exp_d_rdata = 32'h0;
    core_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst no_ack", {core_ack, dma_ack, bus_enable}, 0);
    run_vec(v_post, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
